axil_regfile_sub: RTL and testbench
===================================

Name: axil_regfile_sub

Overview:
Parametrised AXI4-Lite subordinate holding C_NUM_REGS software-visible registers. Successor to the fixed two-register subordinate.
- Independent read and write channels; AW and W accepted in any order.
- Byte strobes, decode-error responses, per-register write pulses to fabric logic.
- Sits behind the AXI4-Lite interconnect as a generic control/status register bank.

Parameters:
C_AXI_DATA_WIDTH, 32, data width in bits (32 or 64)
C_AXI_ADDR_WIDTH, 32, address width in bits
C_NUM_REGS, 8, number of registers (1..256)
C_BASE_ADDR, 0, byte address of register 0 (aligned to C_AXI_DATA_WIDTH/8)
C_ID_VALUE, 32'h0001_0000, read-only ID value used only when the optional feature is compiled in

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
s_axi_araddr  in  C_AXI_ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  C_AXI_DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
s_axi_awaddr  in  C_AXI_ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  C_AXI_DATA_WIDTH  write data
s_axi_wstrb  in  C_AXI_DATA_WIDTH/8  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
reg_q  out  C_NUM_REGS*C_AXI_DATA_WIDTH  flattened register contents; register i at bits [i*W +: W]
reg_wr_pulse  out  C_NUM_REGS  one-cycle pulse per register on a committed write

Behaviour:
- Reset: asynchronous on resetn low. All outputs are 0, all registers are 0, and both FSMs are IDLE. Deassertion takes effect at the next clk edge.
- Decode: idx = (addr - C_BASE_ADDR) >> log2(W/8). Low byte-offset bits are ignored. idx >= C_NUM_REGS, or addr < C_BASE_ADDR, is out of range.
- Responses: in range gives OKAY (2'b00); out of range gives DECERR (2'b11) with rdata 0, and no register changes.
- Read FSM, RD_IDLE -> RD_RESP:
  - s_axi_arready = 1 in RD_IDLE, registered.
  - On an AR handshake, rdata/rresp are loaded and rvalid rises next cycle (1-cycle latency).
  - RD_RESP holds rdata/rresp/rvalid stable until rready; then returns to RD_IDLE with arready = 1 the following cycle.
  - Throughput: one read per 2 cycles minimum.
- Write FSM, states WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP:
  - awready is high in WR_IDLE and WR_HAVE_W; wready is high in WR_IDLE and WR_HAVE_AW.
  - Both handshakes in the same cycle: commit immediately and go to WR_RESP.
  - Otherwise the first beat is latched; the second beat triggers the commit.
  - Commit: each byte k of reg[idx] takes wdata byte k only where wstrb[k] = 1. reg_wr_pulse[idx] = 1 for exactly the cycle after the commit edge, even when wstrb = 0.
  - bvalid rises the cycle after commit. It holds until bready, then returns to WR_IDLE. No new AW/W is accepted while in WR_RESP.
- Simultaneous read and write of the same register: rdata returns the pre-write value (read sampled on the same edge the write commits).
- rresp/bresp/rdata are don't-care-free: they are driven 0 whenever the matching valid is low.
- Reset mid-transaction: the transaction is dropped, no response is issued, and partially latched AW/W are discarded.

Optional Feature:
Macro AXIL_REGS_RDONLY_ID_EN.
- Defined:
  - Register 0 is read-only and always reads C_ID_VALUE (truncated or zero-extended to W).
  - A write to index 0 returns SLVERR (2'b10), changes nothing, and pulses nothing.
  - reg_q slice 0 = C_ID_VALUE.
- Undefined: register 0 is an ordinary read/write register.

Decomposition:
- Package axil_pkg:
  - Response constants RESP_OKAY/RESP_SLVERR/RESP_DECERR.
  - Read and write FSM state enums.
  - Function for the byte-strobe merge.
- One sub-module, axil_addr_decode: combinational address -> {idx, in_range}. Instantiated twice, once for AR and once for AW.

Test Plan:
- Reset with resetn = 0 mid-write (AW accepted, W pending) -> after release bvalid = 0 and reg_q = 0; a fresh write to 0x04 of 0xDEADBEEF commits with bresp 00.
- W before AW by 3 cycles, data 0x12345678, wstrb 4'b0101, to 0x08 holding 0xFFFFFFFF -> reg[2] = 0xFF34FF78, bresp 00, reg_wr_pulse = 8'b0000_0100 for 1 cycle.
- Read of 0x40 with C_NUM_REGS = 8 -> rresp 11, rdata 0. Write to 0x40 -> bresp 11, reg_q unchanged.
- Read of 0x04 with rready held low for 5 cycles -> rvalid/rdata stable throughout; arready stays 0 until a cycle after the rready handshake.
- Same-cycle AR and commit to 0x0C (old 0x1, new 0x2) -> rdata 0x1; a subsequent read returns 0x2.
- With AXIL_REGS_RDONLY_ID_EN defined, write 0xAAAA_AAAA to 0x00 -> bresp 10, then read 0x00 returns 0x0001_0000.

Source files
------------

// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite register-file subordinate:
//   - AXI response codes (OKAY / SLVERR / DECERR)
//   - read and write channel FSM state encodings
//   - strb_merge(): byte-strobe merge of new write data into an old value
// -----------------------------------------------------------------------------
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_RESP = 1'b1
   } rd_state_e;

   typedef enum logic [1:0] {
      WR_IDLE    = 2'd0,
      WR_HAVE_AW = 2'd1,
      WR_HAVE_W  = 2'd2,
      WR_RESP    = 2'd3
   } wr_state_e;

   // Sized for the widest supported bus (64 bits); narrower callers
   // zero-extend the operands and keep the low bits of the result.
   function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
      logic [63:0] res;
      res = old_val;
      for (int k = 0; k < 8; k++) begin
         if (strb[k]) begin
            res[k*8 +: 8] = new_val[k*8 +: 8];
         end else begin
            res[k*8 +: 8] = old_val[k*8 +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/axil_addr_decode.sv
// -----------------------------------------------------------------------------
// axil_addr_decode
// Combinational byte address -> register index decode.
//   addr     : byte address from the AR or AW channel
//   idx      : word index relative to BASE_ADDR (low byte-offset bits dropped)
//   in_range : 1 when BASE_ADDR <= addr and idx < NUM_REGS
// -----------------------------------------------------------------------------
module axil_addr_decode
   import axil_pkg::*;
#(
   parameter int                 ADDR_W    = 32,
   parameter int                 DATA_W    = 32,
   parameter int                 NUM_REGS  = 8,
   parameter int                 IDX_W     = 3,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = {ADDR_W{1'b0}}
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [IDX_W-1:0]  idx,
   output logic              in_range
);

   localparam int                OFS_W      = $clog2(DATA_W / 8);
   localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

   logic [ADDR_W-1:0] rel_s;
   logic [ADDR_W-1:0] word_s;

   // Offset from the bank base, converted to a word index.  The full-width
   // word index is range-checked so that high address bits cannot alias.
   always_comb begin
      rel_s    = addr - BASE_ADDR;
      word_s   = rel_s >> OFS_W;
      idx      = word_s[IDX_W-1:0];
      in_range = (addr >= BASE_ADDR) && (word_s < NUM_REGS_A);
   end

endmodule

// File: rtl/axil_regfile_sub.sv
// -----------------------------------------------------------------------------
// axil_regfile_sub
// AXI4-Lite subordinate exposing C_NUM_REGS software-visible registers.
//   clk, resetn        : clock, asynchronous active-low reset
//   s_axi_ar* / r*     : read address / read data channels (1-cycle latency)
//   s_axi_aw* / w* / b*: write address / data / response channels; AW and W
//                        may arrive in either order or together
//   reg_q              : flattened register contents, reg i at [i*W +: W]
//   reg_wr_pulse       : one-cycle pulse per register on a committed write
// Optional build macro AXIL_REGS_RDONLY_ID_EN: register 0 becomes a
// read-only ID register returning C_ID_VALUE; writes to it get SLVERR.
// -----------------------------------------------------------------------------
module axil_regfile_sub
   import axil_pkg::*;
#(
   parameter int                          C_AXI_DATA_WIDTH = 32,
   parameter int                          C_AXI_ADDR_WIDTH = 32,
   parameter int                          C_NUM_REGS       = 8,
   parameter logic [C_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR      = {C_AXI_ADDR_WIDTH{1'b0}},
   parameter logic [31:0]                 C_ID_VALUE       = 32'h0001_0000
) (
   input  logic                                   clk,
   input  logic                                   resetn,
   input  logic [C_AXI_ADDR_WIDTH-1:0]            s_axi_araddr,
   input  logic                                   s_axi_arvalid,
   output logic                                   s_axi_arready,
   output logic [C_AXI_DATA_WIDTH-1:0]            s_axi_rdata,
   output logic [1:0]                             s_axi_rresp,
   output logic                                   s_axi_rvalid,
   input  logic                                   s_axi_rready,
   input  logic [C_AXI_ADDR_WIDTH-1:0]            s_axi_awaddr,
   input  logic                                   s_axi_awvalid,
   output logic                                   s_axi_awready,
   input  logic [C_AXI_DATA_WIDTH-1:0]            s_axi_wdata,
   input  logic [C_AXI_DATA_WIDTH/8-1:0]          s_axi_wstrb,
   input  logic                                   s_axi_wvalid,
   output logic                                   s_axi_wready,
   output logic [1:0]                             s_axi_bresp,
   output logic                                   s_axi_bvalid,
   input  logic                                   s_axi_bready,
   output logic [C_NUM_REGS*C_AXI_DATA_WIDTH-1:0] reg_q,
   output logic [C_NUM_REGS-1:0]                  reg_wr_pulse
);

   localparam int W      = C_AXI_DATA_WIDTH;
   localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
   localparam int IDX_W  = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

   // ---------------- storage and read view ----------------
   logic [W-1:0]          regs_r      [C_NUM_REGS];
   logic [W-1:0]          reg_view_s  [C_NUM_REGS];

   // ---------------- read channel ----------------
   rd_state_e             rd_state_r, rd_state_n;
   logic                  arready_r, arready_n;
   logic                  rvalid_r, rvalid_n;
   logic [W-1:0]          rdata_r, rdata_n;
   logic [1:0]            rresp_r, rresp_n;
   logic [IDX_W-1:0]      ar_idx_s;
   logic                  ar_in_range_s;
   logic                  ar_hs_s;

   // ---------------- write channel ----------------
   wr_state_e             wr_state_r, wr_state_n;
   logic                  awready_r, awready_n;
   logic                  wready_r, wready_n;
   logic                  bvalid_r, bvalid_n;
   logic [1:0]            bresp_r, bresp_n;
   logic [IDX_W-1:0]      aw_idx_s, aw_idx_r;
   logic                  aw_in_range_s, aw_in_range_r;
   logic [W-1:0]          wdata_r;
   logic [STRB_W-1:0]     wstrb_r;
   logic                  aw_hs_s, w_hs_s;
   logic                  commit_s, cm_ok_s, ro_hit_s;
   logic [IDX_W-1:0]      cm_idx_s;
   logic                  cm_in_range_s;
   logic [W-1:0]          cm_data_s;
   logic [STRB_W-1:0]     cm_strb_s;
   logic [1:0]            cm_resp_s;
   logic [63:0]           merge_s;
   logic [C_NUM_REGS-1:0] pulse_r, pulse_n;

   axil_addr_decode #(
      .ADDR_W(C_AXI_ADDR_WIDTH), .DATA_W(W), .NUM_REGS(C_NUM_REGS),
      .IDX_W(IDX_W), .BASE_ADDR(C_BASE_ADDR)
   ) u_ar_dec (
      .addr(s_axi_araddr), .idx(ar_idx_s), .in_range(ar_in_range_s)
   );

   axil_addr_decode #(
      .ADDR_W(C_AXI_ADDR_WIDTH), .DATA_W(W), .NUM_REGS(C_NUM_REGS),
      .IDX_W(IDX_W), .BASE_ADDR(C_BASE_ADDR)
   ) u_aw_dec (
      .addr(s_axi_awaddr), .idx(aw_idx_s), .in_range(aw_in_range_s)
   );

   assign ar_hs_s = s_axi_arvalid & arready_r;
   assign aw_hs_s = s_axi_awvalid & awready_r;
   assign w_hs_s  = s_axi_wvalid  & wready_r;

   // Software-visible view of the bank; register 0 may be a constant ID.
   always_comb begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
         reg_view_s[i] = regs_r[i];
      end
`ifdef AXIL_REGS_RDONLY_ID_EN
      reg_view_s[0] = W'(C_ID_VALUE);
`endif
   end

   // Read FSM: next state and next registered outputs.
   always_comb begin
      rd_state_n = rd_state_r;
      rvalid_n   = rvalid_r;
      rdata_n    = rdata_r;
      rresp_n    = rresp_r;
      case (rd_state_r)
         RD_IDLE: begin
            if (ar_hs_s) begin
               rd_state_n = RD_RESP;
               rvalid_n   = 1'b1;
               rdata_n    = ar_in_range_s ? reg_view_s[ar_idx_s] : {W{1'b0}};
               rresp_n    = ar_in_range_s ? RESP_OKAY : RESP_DECERR;
            end else begin
               rd_state_n = RD_IDLE;
            end
         end
         RD_RESP: begin
            if (s_axi_rready) begin
               rd_state_n = RD_IDLE;
               rvalid_n   = 1'b0;
               rdata_n    = {W{1'b0}};
               rresp_n    = RESP_OKAY;
            end else begin
               rd_state_n = RD_RESP;
            end
         end
         default: begin
            rd_state_n = RD_IDLE;
            rvalid_n   = 1'b0;
            rdata_n    = {W{1'b0}};
            rresp_n    = RESP_OKAY;
         end
      endcase
      arready_n = (rd_state_n == RD_IDLE);
   end

   // Read FSM state and read-channel output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_state_r <= RD_IDLE;
         arready_r  <= 1'b0;
         rvalid_r   <= 1'b0;
         rdata_r    <= {W{1'b0}};
         rresp_r    <= RESP_OKAY;
      end else begin
         rd_state_r <= rd_state_n;
         arready_r  <= arready_n;
         rvalid_r   <= rvalid_n;
         rdata_r    <= rdata_n;
         rresp_r    <= rresp_n;
      end
   end

   // Write FSM: pick the commit operands (live beat or latched first beat),
   // then next state, response and ready outputs.
   always_comb begin
      wr_state_n    = wr_state_r;
      bvalid_n      = bvalid_r;
      bresp_n       = bresp_r;
      commit_s      = 1'b0;
      cm_idx_s      = aw_idx_r;
      cm_in_range_s = aw_in_range_r;
      cm_data_s     = wdata_r;
      cm_strb_s     = wstrb_r;
      case (wr_state_r)
         WR_IDLE: begin
            cm_idx_s      = aw_idx_s;
            cm_in_range_s = aw_in_range_s;
            cm_data_s     = s_axi_wdata;
            cm_strb_s     = s_axi_wstrb;
            if (aw_hs_s && w_hs_s) begin
               commit_s = 1'b1;
            end else if (aw_hs_s) begin
               wr_state_n = WR_HAVE_AW;
            end else if (w_hs_s) begin
               wr_state_n = WR_HAVE_W;
            end else begin
               wr_state_n = WR_IDLE;
            end
         end
         WR_HAVE_AW: begin
            cm_data_s = s_axi_wdata;
            cm_strb_s = s_axi_wstrb;
            if (w_hs_s) begin
               commit_s = 1'b1;
            end else begin
               wr_state_n = WR_HAVE_AW;
            end
         end
         WR_HAVE_W: begin
            cm_idx_s      = aw_idx_s;
            cm_in_range_s = aw_in_range_s;
            if (aw_hs_s) begin
               commit_s = 1'b1;
            end else begin
               wr_state_n = WR_HAVE_W;
            end
         end
         WR_RESP: begin
            if (s_axi_bready) begin
               wr_state_n = WR_IDLE;
               bvalid_n   = 1'b0;
               bresp_n    = RESP_OKAY;
            end else begin
               wr_state_n = WR_RESP;
            end
         end
         default: begin
            wr_state_n = WR_IDLE;
            bvalid_n   = 1'b0;
            bresp_n    = RESP_OKAY;
         end
      endcase

`ifdef AXIL_REGS_RDONLY_ID_EN
      ro_hit_s = (cm_idx_s == {IDX_W{1'b0}});
`else
      ro_hit_s = 1'b0;
`endif
      cm_ok_s = cm_in_range_s && !ro_hit_s;
      if (!cm_in_range_s) begin
         cm_resp_s = RESP_DECERR;
      end else if (ro_hit_s) begin
         cm_resp_s = RESP_SLVERR;
      end else begin
         cm_resp_s = RESP_OKAY;
      end

      pulse_n = {C_NUM_REGS{1'b0}};
      merge_s = 64'h0;
      if (commit_s) begin
         wr_state_n = WR_RESP;
         bvalid_n   = 1'b1;
         bresp_n    = cm_resp_s;
         if (cm_ok_s) begin
            pulse_n[cm_idx_s] = 1'b1;
            merge_s = strb_merge(64'(regs_r[cm_idx_s]), 64'(cm_data_s), 8'(cm_strb_s));
         end else begin
            merge_s = 64'h0;
         end
      end else begin
         merge_s = 64'h0;
      end

      awready_n = (wr_state_n == WR_IDLE) || (wr_state_n == WR_HAVE_W);
      wready_n  = (wr_state_n == WR_IDLE) || (wr_state_n == WR_HAVE_AW);
   end

   // Write FSM state and write-channel output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_state_r <= WR_IDLE;
         awready_r  <= 1'b0;
         wready_r   <= 1'b0;
         bvalid_r   <= 1'b0;
         bresp_r    <= RESP_OKAY;
         pulse_r    <= {C_NUM_REGS{1'b0}};
      end else begin
         wr_state_r <= wr_state_n;
         awready_r  <= awready_n;
         wready_r   <= wready_n;
         bvalid_r   <= bvalid_n;
         bresp_r    <= bresp_n;
         pulse_r    <= pulse_n;
      end
   end

   // Hold whichever beat arrives first until its partner shows up.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         aw_idx_r      <= {IDX_W{1'b0}};
         aw_in_range_r <= 1'b0;
         wdata_r       <= {W{1'b0}};
         wstrb_r       <= {STRB_W{1'b0}};
      end else begin
         if (aw_hs_s) begin
            aw_idx_r      <= aw_idx_s;
            aw_in_range_r <= aw_in_range_s;
         end
         if (w_hs_s) begin
            wdata_r <= s_axi_wdata;
            wstrb_r <= s_axi_wstrb;
         end
      end
   end

   // Register bank update on an accepted commit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < C_NUM_REGS; i++) begin
            regs_r[i] <= {W{1'b0}};
         end
      end else if (commit_s && cm_ok_s) begin
         regs_r[cm_idx_s] <= merge_s[W-1:0];
      end
   end

   for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_regq
      assign reg_q[g*W +: W] = reg_view_s[g];
   end

   assign s_axi_arready = arready_r;
   assign s_axi_rvalid  = rvalid_r;
   assign s_axi_rdata   = rdata_r;
   assign s_axi_rresp   = rresp_r;
   assign s_axi_awready = awready_r;
   assign s_axi_wready  = wready_r;
   assign s_axi_bvalid  = bvalid_r;
   assign s_axi_bresp   = bresp_r;
   assign reg_wr_pulse  = pulse_r;

endmodule

// File: tb/tb_axil_regfile_sub.sv
// -----------------------------------------------------------------------------
// tb_axil_regfile_sub
// Self-checking bench for axil_regfile_sub (default parameters: 32-bit data,
// 8 registers at base 0).  Expected responses are queued when a transaction
// is driven and popped when the DUT answers; a byte-level model of the
// register bank supplies the expected reg_q.  Stimulus changes and output
// sampling both happen on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_axil_regfile_sub;

   localparam logic [31:0] ID_VAL = 32'h0001_0000;
`ifdef AXIL_REGS_RDONLY_ID_EN
   localparam logic [31:0] EXP_REG0 = ID_VAL;
`else
   localparam logic [31:0] EXP_REG0 = 32'h0000_0000;
`endif

   logic         clk = 1'b0;
   logic         resetn;
   logic [31:0]  s_axi_araddr, s_axi_awaddr, s_axi_wdata, s_axi_rdata;
   logic         s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
   logic         s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
   logic         s_axi_bvalid, s_axi_bready;
   logic [3:0]   s_axi_wstrb;
   logic [1:0]   s_axi_rresp, s_axi_bresp;
   logic [255:0] reg_q;
   logic [7:0]   reg_wr_pulse;

   axil_regfile_sub dut (
      .clk(clk), .resetn(resetn),
      .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  resp;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   exp_t        rd_q[$];
   exp_t        wr_q[$];
   logic [31:0] mem [8];
   vec_t        vecs [12];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] model_flat();
      logic [255:0] f;
      for (int i = 0; i < 8; i++) f[i*32 +: 32] = mem[i];
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mem[i] = 32'h0;
`ifdef AXIL_REGS_RDONLY_ID_EN
      mem[0] = ID_VAL;
`endif
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input int aw_dly, input int w_dly);
      bit         aw_done, w_done, aw_fire, w_fire;
      int         c, idx;
      logic [7:0] exp_pulse;
      exp_t       e;
      aw_done   = 1'b0;
      w_done    = 1'b0;
      c         = 0;
      idx       = int'(addr >> 2);
      exp_pulse = 8'h00;
      if (exp_resp == 2'b00) exp_pulse[idx] = 1'b1;
      wr_q.push_back('{resp: exp_resp, data: 32'h0});
      s_axi_bready = 1'b1;
      s_axi_awaddr = addr;
      s_axi_wdata  = data;
      s_axi_wstrb  = strb;
      while (!(aw_done && w_done) && c < 60) begin
         s_axi_awvalid = !aw_done && (c >= aw_dly);
         s_axi_wvalid  = !w_done && (c >= w_dly);
         aw_fire = s_axi_awvalid && s_axi_awready;
         w_fire  = s_axi_wvalid && s_axi_wready;
         @(negedge clk);
         if (aw_fire) aw_done = 1'b1;
         if (w_fire)  w_done  = 1'b1;
         c++;
      end
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      chk("wr_handshake", 256'({aw_done, w_done}), 256'(2'b11));
      if (exp_resp == 2'b00) begin
         for (int k = 0; k < 4; k++) if (strb[k]) mem[idx][k*8 +: 8] = data[k*8 +: 8];
      end
      e = wr_q.pop_front();
      chk("bvalid_rise", 256'(s_axi_bvalid), 256'(1'b1));
      chk("bresp", 256'(s_axi_bresp), 256'(e.resp));
      chk("wr_pulse", 256'(reg_wr_pulse), 256'(exp_pulse));
      @(negedge clk);
      chk("wr_pulse_one_cycle", 256'(reg_wr_pulse), 256'(8'h00));
      chk("bvalid_clear", 256'(s_axi_bvalid), 256'(1'b0));
      chk("reg_q", reg_q, model_flat());
      s_axi_bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [1:0] exp_resp,
                          input logic [31:0] exp_data, input int hold);
      bit          ar_done, ar_fire;
      int          c;
      logic [31:0] first;
      exp_t        e;
      rd_q.push_back('{resp: exp_resp, data: exp_data});
      s_axi_rready = (hold == 0);
      ar_done      = 1'b0;
      c            = 0;
      while (!ar_done && c < 60) begin
         s_axi_arvalid = 1'b1;
         s_axi_araddr  = addr;
         ar_fire       = s_axi_arready;
         @(negedge clk);
         if (ar_fire) ar_done = 1'b1;
         c++;
      end
      s_axi_arvalid = 1'b0;
      chk("ar_handshake", 256'(ar_done), 256'(1'b1));
      chk("rvalid_rise", 256'(s_axi_rvalid), 256'(1'b1));
      first = s_axi_rdata;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk("rvalid_hold", 256'(s_axi_rvalid), 256'(1'b1));
         chk("rdata_stable", 256'(s_axi_rdata), 256'(first));
         chk("arready_busy", 256'(s_axi_arready), 256'(1'b0));
      end
      e = rd_q.pop_front();
      chk("rresp", 256'(s_axi_rresp), 256'(e.resp));
      chk("rdata", 256'(s_axi_rdata), 256'(e.data));
      s_axi_rready = 1'b1;
      @(negedge clk);
      s_axi_rready = 1'b0;
      chk("rvalid_clear", 256'(s_axi_rvalid), 256'(1'b0));
      chk("rdata_zero_idle", 256'(s_axi_rdata), 256'(32'h0));
      chk("arready_back", 256'(s_axi_arready), 256'(1'b1));
   endtask

   // Hard stop in case something outside the bounded loops stalls.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
      vecs[1]  = '{1'b0, 32'h04, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
      vecs[3]  = '{1'b1, 32'h1C, 32'hCAFE_F00D, 4'hC, 2'b00, 32'h0};
      vecs[4]  = '{1'b0, 32'h1C, 32'h0,         4'h0, 2'b00, 32'hCAFE_0000};
      vecs[5]  = '{1'b0, 32'h40, 32'h0,         4'h0, 2'b11, 32'h0};
      vecs[6]  = '{1'b1, 32'h40, 32'h0123_4567, 4'hF, 2'b11, 32'h0};
      vecs[7]  = '{1'b0, 32'h07, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
      vecs[8]  = '{1'b1, 32'h10, 32'h1122_3344, 4'h0, 2'b00, 32'h0};
      vecs[9]  = '{1'b0, 32'h10, 32'h0,         4'h0, 2'b00, 32'h0};
      vecs[10] = '{1'b0, 32'h00, 32'h0,         4'h0, 2'b00, EXP_REG0};
      vecs[11] = '{1'b1, 32'h0C, 32'h0000_0001, 4'hF, 2'b00, 32'h0};

      resetn = 1'b0;
      s_axi_araddr = 32'h0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
      s_axi_awaddr = 32'h0; s_axi_awvalid = 1'b0; s_axi_wdata = 32'h0;
      s_axi_wstrb  = 4'h0;  s_axi_wvalid  = 1'b0; s_axi_bready = 1'b0;
      model_reset();

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_arready", 256'(s_axi_arready), 256'(1'b0));
      chk("rst_awready", 256'(s_axi_awready), 256'(1'b0));
      chk("rst_wready", 256'(s_axi_wready), 256'(1'b0));
      chk("rst_rvalid", 256'(s_axi_rvalid), 256'(1'b0));
      chk("rst_bvalid", 256'(s_axi_bvalid), 256'(1'b0));
      chk("rst_pulse", 256'(reg_wr_pulse), 256'(8'h00));
      chk("rst_reg_q", reg_q, model_flat());
      resetn = 1'b1;
      @(negedge clk);
      chk("idle_arready", 256'(s_axi_arready), 256'(1'b1));
      chk("idle_awready", 256'(s_axi_awready), 256'(1'b1));
      chk("idle_wready", 256'(s_axi_wready), 256'(1'b1));

      // Reset in the middle of a write: AW accepted, W never sent.
      s_axi_awaddr  = 32'h04;
      s_axi_awvalid = 1'b1;
      @(negedge clk);
      s_axi_awvalid = 1'b0;
      chk("have_aw_awready", 256'(s_axi_awready), 256'(1'b0));
      chk("have_aw_wready", 256'(s_axi_wready), 256'(1'b1));
      resetn = 1'b0;
      #1;
      chk("async_rst_wready", 256'(s_axi_wready), 256'(1'b0));
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_bvalid", 256'(s_axi_bvalid), 256'(1'b0));
      chk("post_rst_reg_q", reg_q, model_flat());
      chk("post_rst_awready", 256'(s_axi_awready), 256'(1'b1));

      // Table-driven transactions with varied AW/W ordering.
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].is_wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp,
                     (i % 3 == 1) ? 1 : 0, (i % 3 == 2) ? 2 : 0);
         end else begin
            do_read(vecs[i].addr, vecs[i].resp, vecs[i].rdata, 0);
         end
      end

      // W three cycles ahead of AW with partial strobes onto 0xFFFFFFFF.
      do_write(32'h08, 32'h1234_5678, 4'b0101, 2'b00, 3, 0);
      chk("w_first_reg2", 256'(reg_q[95:64]), 256'(32'hFF34_FF78));

      // Read held off by rready for five cycles.
      do_read(32'h04, 2'b00, 32'hDEAD_BEEF, 5);

      // AR handshake on the same edge as a commit to the same register.
      fork
         do_write(32'h0C, 32'h0000_0002, 4'hF, 2'b00, 0, 0);
         do_read(32'h0C, 2'b00, 32'h0000_0001, 0);
      join
      do_read(32'h0C, 2'b00, 32'h0000_0002, 0);

`ifdef AXIL_REGS_RDONLY_ID_EN
      // Register 0 is the read-only ID register.
      do_write(32'h00, 32'hAAAA_AAAA, 4'hF, 2'b10, 0, 0);
      do_read(32'h00, 2'b00, ID_VAL, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
